// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment bus.
// Segment codes are active low on leds[6:0] = {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned DIGIT_COUNT = 4;

    // Bit positions inside leds[7:0] = {dp,g,f,e,d,c,b,a}
    localparam int unsigned SEG_A_BIT  = 0;
    localparam int unsigned SEG_G_BIT  = 6;
    localparam int unsigned SEG_DP_BIT = 7;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [3:0] SEG_INVALID_DIGIT = 4'hF;

    typedef logic [1:0] slot_t;
    typedef logic [DIGIT_COUNT-1:0][3:0] frame_t;

    // True when any digit of the frame failed to decode
    function automatic logic frame_has_invalid(frame_t f);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGIT_COUNT; i++) begin
            bad = bad | (f[i] == SEG_INVALID_DIGIT);
        end
        return bad;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern back to a BCD digit.
// Unknown patterns report valid_o=0 and digit_o=SEG_INVALID_DIGIT.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] digit_o
);

    // Pattern lookup; dp is not part of the pattern
    always_comb begin
        valid_o = 1'b1;
        digit_o = SEG_INVALID_DIGIT;
        case (seg_i)
            SEG_0:   digit_o = 4'd0;
            SEG_1:   digit_o = 4'd1;
            SEG_2:   digit_o = 4'd2;
            SEG_3:   digit_o = 4'd3;
            SEG_4:   digit_o = 4'd4;
            SEG_5:   digit_o = 4'd5;
            SEG_6:   digit_o = 4'd6;
            SEG_7:   digit_o = 4'd7;
            SEG_8:   digit_o = 4'd8;
            SEG_9:   digit_o = 4'd9;
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the 4-digit multiplexed seven-segment bus.
// Synchronises the bus, waits for each digit to settle, samples it once per activation,
// assembles a 4-digit frame and offers it on a valid/ready port.
// Optional build macro: SEG7_DP_CAPTURE_EN adds decimal-point capture and the dp_o port.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gnd_1_i,
    input  logic        gnd_2_i,
    input  logic        gnd_3_i,
    input  logic        gnd_4_i,
    input  logic [7:0]  leds_i,
    output logic        frame_valid_o,
    input  logic        frame_ready_i,
    output logic [15:0] digits_o,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        signal_lost_o
`ifdef SEG7_DP_CAPTURE_EN
    ,
    output logic [3:0]  dp_o
`endif
);

    // Bus layout after synchronisation: [3:0] enables, [10:4] segments, [11] dp (optional)
    localparam int unsigned SegLsb = DIGIT_COUNT;
`ifdef SEG7_DP_CAPTURE_EN
    localparam int unsigned BusW = DIGIT_COUNT + 8;
`else
    localparam int unsigned BusW = DIGIT_COUNT + 7;
`endif
    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoMax     = TmoW'(TIMEOUT_CYCLES);

    logic [BusW-1:0]                  bus_raw;
    logic [SYNC_STAGES-1:0][BusW-1:0] sync_q;
    logic [BusW-1:0]                  bus_s;

`ifdef SEG7_DP_CAPTURE_EN
    assign bus_raw = {leds_i, gnd_4_i, gnd_3_i, gnd_2_i, gnd_1_i};
`else
    logic unused_leds_dp;
    assign unused_leds_dp = leds_i[SEG_DP_BIT];
    assign bus_raw = {leds_i[6:0], gnd_4_i, gnd_3_i, gnd_2_i, gnd_1_i};
`endif

    // Synchroniser; resets to an idle bus (enables high, segments dark)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= bus_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign bus_s = sync_q[SYNC_STAGES-1];

    logic [DIGIT_COUNT-1:0] en_s;
    logic [6:0]             seg_s;
    slot_t                  slot;
    logic                   slot_vld;

    assign en_s  = ~bus_s[DIGIT_COUNT-1:0];
    assign seg_s = bus_s[SegLsb + SEG_G_BIT : SegLsb + SEG_A_BIT];

    // Exactly one active enable selects a slot; anything else means no slot
    always_comb begin
        slot_vld = 1'b1;
        slot     = '0;
        case (en_s)
            4'b0001: slot = 2'd0;
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            4'b1000: slot = 2'd3;
            default: slot_vld = 1'b0;
        endcase
    end

    logic       dec_valid;
    logic [3:0] dec_digit;
    logic [3:0] digit;

    seg7_pattern_decode u_decode (
        .seg_i   (seg_s),
        .valid_o (dec_valid),
        .digit_o (dec_digit)
    );

    assign digit = dec_valid ? dec_digit : SEG_INVALID_DIGIT;

    // State
    logic                   prev_vld_q;
    slot_t                  prev_slot_q;
    logic [6:0]             prev_seg_q;
    logic [CntW-1:0]        settle_q, settle_d;
    logic                   sampled_q, sampled_d;
    logic [TmoW-1:0]        tmo_q, tmo_d;
    logic                   lost_q, lost_d;
    logic [DIGIT_COUNT-1:0] mask_q, mask_d;
    frame_t                 shadow_q, shadow_d;
    logic                   valid_q, valid_d;
    frame_t                 digits_q, digits_d;
    logic                   err_q, err_d;
    logic                   overrun_q, overrun_d;

    logic stable, sample, tmo_sat, complete, load, handshake;

    // Settle, timeout, shadow frame and output register next-state
    always_comb begin
        stable = slot_vld && prev_vld_q && (slot == prev_slot_q) && (seg_s == prev_seg_q);

        settle_d = settle_q;
        if (!stable) begin
            settle_d = '0;
        end else if (settle_q != SettleLast) begin
            settle_d = settle_q + 1'b1;
        end
        // Fire on the cycle the counter steps onto its last value, once per activation
        sample    = stable && !sampled_q && (settle_d == SettleLast);
        sampled_d = stable && (sampled_q || sample);

        tmo_sat = (tmo_q == TmoMax);
        tmo_d   = tmo_q;
        lost_d  = lost_q;
        if (sample) begin
            tmo_d  = '0;
            lost_d = 1'b0;
        end else if (tmo_sat) begin
            lost_d = 1'b1;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        complete  = (mask_q == '1);
        handshake = valid_q && frame_ready_i;
        load      = complete && (!valid_q || frame_ready_i);

        // Completion and timeout clear first so a same-cycle sample opens the next frame
        mask_d   = mask_q;
        shadow_d = shadow_q;
        if (complete || tmo_sat) begin
            mask_d = '0;
        end
        if (sample) begin
            mask_d[slot]   = 1'b1;
            shadow_d[slot] = digit;
        end

        valid_d   = valid_q;
        digits_d  = digits_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        if (load) begin
            valid_d  = 1'b1;
            digits_d = shadow_q;
            err_d    = frame_has_invalid(shadow_q);
        end else if (handshake) begin
            valid_d = 1'b0;
        end
        if (complete && !load) begin
            overrun_d = 1'b1;
        end else if (handshake) begin
            overrun_d = 1'b0;
        end
    end

    // Capture state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_vld_q  <= 1'b0;
            prev_slot_q <= '0;
            prev_seg_q  <= '0;
            settle_q    <= '0;
            sampled_q   <= 1'b0;
            tmo_q       <= '0;
            lost_q      <= 1'b0;
            mask_q      <= '0;
            shadow_q    <= '0;
            valid_q     <= 1'b0;
            digits_q    <= '0;
            err_q       <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            prev_vld_q  <= slot_vld;
            prev_slot_q <= slot;
            prev_seg_q  <= seg_s;
            settle_q    <= settle_d;
            sampled_q   <= sampled_d;
            tmo_q       <= tmo_d;
            lost_q      <= lost_d;
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            valid_q     <= valid_d;
            digits_q    <= digits_d;
            err_q       <= err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    logic [DIGIT_COUNT-1:0] shadow_dp_q;
    logic [DIGIT_COUNT-1:0] dp_q;

    // Decimal points ride along with the digits; leds[7] is active low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dp_q <= '0;
            dp_q        <= '0;
        end else begin
            if (sample) begin
                shadow_dp_q[slot] <= ~bus_s[SegLsb + SEG_DP_BIT];
            end
            if (load) begin
                dp_q <= shadow_dp_q;
            end
        end
    end

    assign dp_o = dp_q;
`endif

    assign frame_valid_o = valid_q;
    assign digits_o      = digits_q;
    assign frame_err_o   = err_q;
    assign overrun_o     = overrun_q;
    assign signal_lost_o = lost_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: a frame-level model pushes expected frames,
// a monitor compares them against every frame the DUT presents.
module tb_seg7_scan_capture;

    localparam int unsigned Settle      = 64;
    localparam int unsigned Timeout     = 3000;
    localparam int unsigned Sync        = 2;
    localparam int unsigned DigitCycles = 200;
    localparam int unsigned BlankCycles = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gnd_1 = 1'b1, gnd_2 = 1'b1, gnd_3 = 1'b1, gnd_4 = 1'b1;
    logic [7:0]  leds = 8'hFF;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [15:0] digits;
    logic        frame_err;
    logic        overrun;
    logic        signal_lost;
`ifdef SEG7_DP_CAPTURE_EN
    logic [3:0]  dp;
`endif

    seg7_scan_capture #(
        .SETTLE_CYCLES  (Settle),
        .TIMEOUT_CYCLES (Timeout),
        .SYNC_STAGES    (Sync)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gnd_1_i       (gnd_1),
        .gnd_2_i       (gnd_2),
        .gnd_3_i       (gnd_3),
        .gnd_4_i       (gnd_4),
        .leds_i        (leds),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .digits_o      (digits),
        .frame_err_o   (frame_err),
        .overrun_o     (overrun),
        .signal_lost_o (signal_lost)
`ifdef SEG7_DP_CAPTURE_EN
        ,
        .dp_o          (dp)
`endif
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] digits;
        logic        err;
        logic [3:0]  dp;
    } exp_t;

    exp_t       exp_q[$];
    logic [6:0] seg_tab[10];
    logic [3:0] m_val[4];
    logic       m_dp[4];
    logic [3:0] m_mask = 4'h0;
    bit         m_hold = 0;     // consumer is holding ready low
    bit         m_full = 0;     // a frame is parked at the output
    logic       m_overrun = 1'b0;
    int         ready_mode = 1; // 0: ready low, 1: ready high, 2: random

    function automatic logic [3:0] model_decode(logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (seg_tab[i] == p) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic model_sample(input int slot, input logic [6:0] pat, input logic lit);
        exp_t e;
        m_val[slot]  = model_decode(pat);
        m_dp[slot]   = lit;
        m_mask[slot] = 1'b1;
        if (m_mask == 4'hF) begin
            m_mask = 4'h0;
            if (m_hold && m_full) begin
                m_overrun = 1'b1;
            end else begin
                e.digits = {m_val[3], m_val[2], m_val[1], m_val[0]};
                e.err    = 1'b0;
                for (int i = 0; i < 4; i++) if (m_val[i] == 4'hF) e.err = 1'b1;
                e.dp     = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
                exp_q.push_back(e);
                if (m_hold) m_full = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: any presented frame must match the oldest expected one
    initial forever begin
        @(negedge clk);
        if (rst_n && frame_valid) begin
            if (exp_q.size() == 0) begin
                if (frame_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%h required=none", digits);
                end
            end else begin
                check("frame_digits", 32'(digits), 32'(exp_q[0].digits));
                check("frame_err", 32'(frame_err), 32'(exp_q[0].err));
`ifdef SEG7_DP_CAPTURE_EN
                check("frame_dp", 32'(dp), 32'(exp_q[0].dp));
`endif
                if (frame_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Consumer ready driver
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       frame_ready = 1'b0;
            1:       frame_ready = 1'b1;
            default: frame_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Watchdog
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en_n, input logic [7:0] l);
        {gnd_4, gnd_3, gnd_2, gnd_1} = en_n;
        leds = l;
    endtask

    task automatic show(input int slot, input logic [6:0] pat, input logic lit,
                        input int n, input bit mdl);
        if (mdl) model_sample(slot, pat, lit);
        drive(~(4'b0001 << slot), {~lit, pat});
        tick(n);
        drive(4'hF, {~lit, pat});
        tick(BlankCycles);
    endtask

    task automatic scan(input logic [27:0] pats, input logic [3:0] lits);
        for (int k = 0; k < 4; k++) show(k, pats[7*k +: 7], lits[k], DigitCycles, 1);
    endtask

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(0, 9) == 0) return 7'($urandom);
        return seg_tab[$urandom_range(0, 9)];
    endfunction

    task automatic rand_scan();
        logic [27:0] p;
        for (int k = 0; k < 4; k++) p[7*k +: 7] = rand_pat();
        scan(p, 4'($urandom));
    endtask

    task automatic drained(input string name);
        tick(5);
        check({name, "_pending"}, 32'(exp_q.size()), 0);
        check({name, "_valid"}, 32'(frame_valid), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_valid"}, 32'(frame_valid), 0);
        check({name, "_digits"}, 32'(digits), 0);
        check({name, "_err"}, 32'(frame_err), 0);
        check({name, "_overrun"}, 32'(overrun), 0);
        check({name, "_lost"}, 32'(signal_lost), 0);
`ifdef SEG7_DP_CAPTURE_EN
        check({name, "_dp"}, 32'(dp), 0);
`endif
    endtask

    initial begin
        seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
        seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
        seg_tab[8] = 7'h00; seg_tab[9] = 7'h10;
        for (int i = 0; i < 4; i++) begin
            m_val[i] = 4'h0;
            m_dp[i]  = 1'b0;
        end

        // Reset state
        drive(4'hF, 8'hFF);
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // 1: digits 1,2,3,4 with ready high
        scan({seg_tab[4], seg_tab[3], seg_tab[2], seg_tab[1]}, 4'b0000);
        drained("t1");

        // Random scans with a randomly stalling consumer
        ready_mode = 2;
        for (int s = 0; s < 6; s++) rand_scan();
        ready_mode = 1;
        tick(10);
        check("rand_overrun", 32'(overrun), 32'(m_overrun));
        drained("rand");

        // 2: ready held low across two scans -> first frame parked, second dropped
        ready_mode = 0;
        m_hold = 1;
        tick(2);
        rand_scan();
        rand_scan();
        check("t2_overrun_set", 32'(overrun), 32'(m_overrun));
        check("t2_valid_held", 32'(frame_valid), 1);
        check("t2_queue", 32'(exp_q.size()), 1);
        if (exp_q.size() > 0) check("t2_held_digits", 32'(digits), 32'(exp_q[0].digits));
        ready_mode = 1;
        m_hold = 0;
        m_full = 0;
        m_overrun = 1'b0;
        tick(3);
        check("t2_overrun_clr", 32'(overrun), 32'(m_overrun));
        drained("t2");

        // 3: blank pattern on digit2 -> undecodable
        scan({seg_tab[7], 7'h7F, seg_tab[0], seg_tab[9]}, 4'b0000);
        drained("t3");

        // 4: two enables at once, then a short glitch, neither may be sampled
        show(0, seg_tab[6], 1'b0, DigitCycles, 1);
        show(1, seg_tab[2], 1'b0, DigitCycles, 1);
        show(3, seg_tab[9], 1'b0, DigitCycles, 1);
        drive(4'b1010, {1'b1, seg_tab[8]});
        tick(1000);
        show(2, seg_tab[7], 1'b0, 20, 0);
        show(2, seg_tab[5], 1'b0, DigitCycles, 1);
        drained("t4");

        // 5: timeout discards a partial frame, resumed scan delivers
        show(0, seg_tab[3], 1'b0, DigitCycles, 1);
        show(1, seg_tab[1], 1'b0, DigitCycles, 1);
        drive(4'hF, 8'hFF);
        tick(Timeout + 100);
        m_mask = 4'h0;
        check("t5_lost_set", 32'(signal_lost), 1);
        show(2, seg_tab[4], 1'b0, DigitCycles, 1);
        check("t5_lost_clr", 32'(signal_lost), 0);
        show(3, seg_tab[8], 1'b0, DigitCycles, 1);
        show(0, seg_tab[0], 1'b0, DigitCycles, 1);
        show(1, seg_tab[6], 1'b0, DigitCycles, 1);
        drained("t5");

        // 6: reset with a parked frame and a partial frame pending
        ready_mode = 0;
        m_hold = 1;
        tick(2);
        rand_scan();
        show(0, seg_tab[5], 1'b0, DigitCycles, 1);
        show(1, seg_tab[5], 1'b0, DigitCycles, 1);
        check("t6_parked", 32'(frame_valid), 1);
        rst_n = 1'b0;
        exp_q.delete();
        m_mask = 4'h0;
        m_full = 0;
        m_hold = 0;
        m_overrun = 1'b0;
        tick(2);
        check_idle_outputs("t6_reset");
        rst_n = 1'b1;
        ready_mode = 1;
        tick(2);
        scan({seg_tab[1], seg_tab[9], seg_tab[8], seg_tab[2]}, 4'b0010);
        drained("t6");

        check("end_overrun", 32'(overrun), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
